// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the shared-ALU arbiter.
// ALUOP_NOP must match `ALUOp_nop in ctrl_encode_def.v.
package alu_arb_pkg;

    localparam int HART_W      = 1;
    localparam int DATA_W_DEF  = 32;
    localparam int ALUOP_W_DEF = 5;
    localparam int PERF_W      = 32;

    typedef logic [HART_W-1:0] hart_t;

    // Hart 0 wins the first conflict after reset.
    localparam hart_t LAST_GRANT_RST = 1'b1;

    localparam logic [ALUOP_W_DEF-1:0] ALUOP_NOP = 5'b00000;

    function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
        return (v == 32'hFFFF_FFFF) ? v : (v + 32'd1);
    endfunction

endpackage

// File: rtl/alu_share_arb_rr_arb2.sv
// 2-way round-robin grant: a lone requester wins; on conflict the hart
// other than last_grant wins. Purely combinational.
module rr_arb2
    import alu_arb_pkg::*;
(
    input  logic [1:0] valid,
    input  hart_t      last_grant,
    output logic [1:0] grant
);

    // grant selection from request vector and priority pointer
    always_comb begin
        grant = 2'b00;
        case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11: begin
                if (last_grant == 1'b1) begin
                    grant = 2'b01;
                end else begin
                    grant = 2'b10;
                end
            end
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/alu_share_arb.sv
// Time-shares one combinational ALU between two hart issue slots with a
// round-robin grant and a tagged result register. Optional perf counters
// are enabled by defining ALU_ARB_PERF_EN.
module alu_share_arb
    import alu_arb_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ALUOP_W = ALUOP_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         req_valid,
    output logic [1:0]         req_ready,
    input  logic [DATA_W-1:0]  req_a0,
    input  logic [DATA_W-1:0]  req_a1,
    input  logic [DATA_W-1:0]  req_b0,
    input  logic [DATA_W-1:0]  req_b1,
    input  logic [ALUOP_W-1:0] req_op0,
    input  logic [ALUOP_W-1:0] req_op1,
    input  logic [31:0]        req_pc0,
    input  logic [31:0]        req_pc1,
    output logic [DATA_W-1:0]  alu_a,
    output logic [DATA_W-1:0]  alu_b,
    output logic [ALUOP_W-1:0] alu_op,
    output logic [31:0]        alu_pc,
    input  logic [DATA_W-1:0]  alu_c,
    input  logic               alu_zero,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic               resp_hart,
    output logic [DATA_W-1:0]  resp_c,
    output logic               resp_zero
`ifdef ALU_ARB_PERF_EN
    ,
    output logic [31:0]        perf_grant0,
    output logic [31:0]        perf_grant1,
    output logic [31:0]        perf_conflict
`endif
);

    logic              space_s;
    logic [1:0]        grant_s;
    logic              xfer_s;
    hart_t             xfer_hart_s;
    hart_t             last_grant_r;
    logic              resp_valid_r;
    hart_t             resp_hart_r;
    logic [DATA_W-1:0] resp_c_r;
    logic              resp_zero_r;

    rr_arb2 u_rr_arb2 (
        .valid      (req_valid),
        .last_grant (last_grant_r),
        .grant      (grant_s)
    );

    // A grant only becomes a transfer when the result register can take it.
    assign space_s     = !resp_valid_r || resp_ready;
    assign req_ready   = grant_s & {2{space_s}};
    assign xfer_s      = |req_ready;
    assign xfer_hart_s = req_ready[1];

    // route the granted hart's operands onto the shared ALU
    always_comb begin
        alu_a  = '0;
        alu_b  = '0;
        alu_op = ALUOP_W'(ALUOP_NOP);
        alu_pc = 32'h0000_0000;
        case (grant_s)
            2'b01: begin
                alu_a  = req_a0;
                alu_b  = req_b0;
                alu_op = req_op0;
                alu_pc = req_pc0;
            end
            2'b10: begin
                alu_a  = req_a1;
                alu_b  = req_b1;
                alu_op = req_op1;
                alu_pc = req_pc1;
            end
            default: begin
                alu_a  = '0;
                alu_b  = '0;
                alu_op = ALUOP_W'(ALUOP_NOP);
                alu_pc = 32'h0000_0000;
            end
        endcase
    end

    // result register and round-robin pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid_r <= 1'b0;
            resp_hart_r  <= 1'b0;
            resp_c_r     <= '0;
            resp_zero_r  <= 1'b0;
            last_grant_r <= LAST_GRANT_RST;
        end else if (xfer_s) begin
            resp_valid_r <= 1'b1;
            resp_hart_r  <= xfer_hart_s;
            resp_c_r     <= alu_c;
            resp_zero_r  <= alu_zero;
            last_grant_r <= xfer_hart_s;
        end else if (resp_ready) begin
            resp_valid_r <= 1'b0;
        end
    end

    assign resp_valid = resp_valid_r;
    assign resp_hart  = resp_hart_r;
    assign resp_c     = resp_c_r;
    assign resp_zero  = resp_zero_r;

`ifdef ALU_ARB_PERF_EN
    logic [31:0] perf_grant0_r;
    logic [31:0] perf_grant1_r;
    logic [31:0] perf_conflict_r;

    // saturating transfer and conflict counters
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_grant0_r   <= 32'd0;
            perf_grant1_r   <= 32'd0;
            perf_conflict_r <= 32'd0;
        end else begin
            if (xfer_s && (xfer_hart_s == 1'b0)) begin
                perf_grant0_r <= sat_inc(perf_grant0_r);
            end
            if (xfer_s && (xfer_hart_s == 1'b1)) begin
                perf_grant1_r <= sat_inc(perf_grant1_r);
            end
            if ((&req_valid) && space_s) begin
                perf_conflict_r <= sat_inc(perf_conflict_r);
            end
        end
    end

    assign perf_grant0   = perf_grant0_r;
    assign perf_grant1   = perf_grant1_r;
    assign perf_conflict = perf_conflict_r;
`endif

endmodule

// File: tb/tb_alu_share_arb.sv
// Scoreboard bench for alu_share_arb: directed stimulus pushes hand-computed
// results; a negedge monitor pops them on every resp handshake.
module tb_alu_share_arb;

    localparam logic [4:0] OP_NOP   = 5'b00000;
    localparam logic [4:0] OP_AUIPC = 5'b00010;
    localparam logic [4:0] OP_ADD   = 5'b00011;
    localparam logic [4:0] OP_SUB   = 5'b00100;
    localparam logic [4:0] OP_OR    = 5'b01101;

    typedef struct {
        logic        hart;
        logic [31:0] c;
        logic        zero;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [31:0] req_a0, req_a1, req_b0, req_b1, req_pc0, req_pc1;
    logic [4:0]  req_op0, req_op1;
    logic [31:0] alu_a, alu_b, alu_pc, alu_c;
    logic [4:0]  alu_op;
    logic        alu_zero;
    logic        resp_valid, resp_ready, resp_hart, resp_zero;
    logic [31:0] resp_c;
`ifdef ALU_ARB_PERF_EN
    logic [31:0] perf_grant0, perf_grant1, perf_conflict;
`endif

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    alu_share_arb dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a0     (req_a0),
        .req_a1     (req_a1),
        .req_b0     (req_b0),
        .req_b1     (req_b1),
        .req_op0    (req_op0),
        .req_op1    (req_op1),
        .req_pc0    (req_pc0),
        .req_pc1    (req_pc1),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_pc     (alu_pc),
        .alu_c      (alu_c),
        .alu_zero   (alu_zero),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_hart  (resp_hart),
        .resp_c     (resp_c),
        .resp_zero  (resp_zero)
`ifdef ALU_ARB_PERF_EN
        ,
        .perf_grant0   (perf_grant0),
        .perf_grant1   (perf_grant1),
        .perf_conflict (perf_conflict)
`endif
    );

    // Stand-in for the shared ALU, covering only the opcodes used here.
    always_comb begin
        case (alu_op)
            OP_ADD:   alu_c = alu_a + alu_b;
            OP_SUB:   alu_c = alu_a - alu_b;
            OP_OR:    alu_c = alu_a | alu_b;
            OP_AUIPC: alu_c = alu_pc + alu_b;
            default:  alu_c = 32'h0000_0000;
        endcase
        alu_zero = (alu_c == 32'h0000_0000);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic push(input logic h, input logic [31:0] c, input logic z);
        exp_t e;
        e.hart = h;
        e.c    = c;
        e.zero = z;
        sb_q.push_back(e);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // monitor: every accepted response must match the oldest expectation
    always @(negedge clk) begin
        if (!rst && resp_valid && resp_ready) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_resp: got hart=%0d c=%h, want none", resp_hart, resp_c);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("resp_hart", {31'd0, resp_hart}, {31'd0, e.hart});
                chk("resp_c", resp_c, e.c);
                chk("resp_zero", {31'd0, resp_zero}, {31'd0, e.zero});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        req_valid = 2'b00;
        resp_ready = 1'b1;
        req_a0 = 32'd0; req_a1 = 32'd0; req_b0 = 32'd0; req_b1 = 32'd0;
        req_pc0 = 32'd0; req_pc1 = 32'd0; req_op0 = OP_NOP; req_op1 = OP_NOP;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // reset state and idle ALU drive
        @(negedge clk);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_hart", {31'd0, resp_hart}, 32'd0);
        chk("rst_resp_c", resp_c, 32'd0);
        chk("rst_resp_zero", {31'd0, resp_zero}, 32'd0);
        chk("rst_req_ready", {30'd0, req_ready}, 32'd0);
        chk("rst_alu_op", {27'd0, alu_op}, {27'd0, OP_NOP});

        // single hart: 5 + 7
        next_cycle();
        req_valid = 2'b01; req_a0 = 32'd5; req_b0 = 32'd7; req_op0 = OP_ADD;
        push(1'b0, 32'd12, 1'b0);
        @(negedge clk);
        chk("single_req_ready", {30'd0, req_ready}, 32'd1);
        chk("single_alu_a", alu_a, 32'd5);
        chk("single_alu_b", alu_b, 32'd7);
        chk("single_alu_op", {27'd0, alu_op}, {27'd0, OP_ADD});
        next_cycle();
        req_valid = 2'b00;
        @(negedge clk);
        chk("single_resp_valid", {31'd0, resp_valid}, 32'd1);

        next_cycle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;

        // conflict after reset: hart0 (3-3) then hart1 (1|2), alternating
        for (int i = 0; i < 6; i++) begin
            req_valid = 2'b11;
            req_a0 = 32'd3; req_b0 = 32'd3; req_op0 = OP_SUB;
            req_a1 = 32'd1; req_b1 = 32'd2; req_op1 = OP_OR;
            if (i % 2 == 0) push(1'b0, 32'd0, 1'b1);
            else            push(1'b1, 32'd3, 1'b0);
            @(negedge clk);
            chk("conflict_req_ready", {30'd0, req_ready}, (i % 2 == 0) ? 32'd1 : 32'd2);
            next_cycle();
        end

        // backpressure: hart1 result (3) held, no grants, no rotation
        resp_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("bp_req_ready", {30'd0, req_ready}, 32'd0);
            chk("bp_resp_valid", {31'd0, resp_valid}, 32'd1);
            chk("bp_resp_hart", {31'd0, resp_hart}, 32'd1);
            chk("bp_resp_c", resp_c, 32'd3);
            next_cycle();
        end
        resp_ready = 1'b1;
        push(1'b0, 32'd0, 1'b1);
        @(negedge clk);
        chk("bp_release_req_ready", {30'd0, req_ready}, 32'd1);

        // idle drive, then drain
        next_cycle();
        req_valid = 2'b00;
        @(negedge clk);
        chk("idle_alu_op", {27'd0, alu_op}, {27'd0, OP_NOP});
        chk("idle_alu_a", alu_a, 32'd0);
        chk("idle_alu_b", alu_b, 32'd0);
        chk("idle_alu_pc", alu_pc, 32'd0);
        chk("idle_req_ready", {30'd0, req_ready}, 32'd0);
        next_cycle();
        @(negedge clk);
        chk("idle_resp_valid", {31'd0, resp_valid}, 32'd0);

        // auipc routing on hart1
        next_cycle();
        req_valid = 2'b10; req_op1 = OP_AUIPC; req_a1 = 32'hDEAD_BEEF;
        req_b1 = 32'h0000_2000; req_pc1 = 32'h0000_1000; req_pc0 = 32'h0000_4444;
        push(1'b1, 32'h0000_3000, 1'b0);
        @(negedge clk);
        chk("auipc_req_ready", {30'd0, req_ready}, 32'd2);
        chk("auipc_alu_pc", alu_pc, 32'h0000_1000);
        chk("auipc_alu_b", alu_b, 32'h0000_2000);
        next_cycle();
        req_valid = 2'b00;
        @(negedge clk);
        chk("auipc_resp_valid", {31'd0, resp_valid}, 32'd1);

        // reset mid-operation after 3 grants, 1 conflict
        next_cycle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        req_valid = 2'b11;
        req_a0 = 32'd5; req_b0 = 32'd7; req_op0 = OP_ADD;
        req_a1 = 32'd1; req_b1 = 32'd2; req_op1 = OP_OR;
        push(1'b0, 32'd12, 1'b0);
        @(negedge clk);
        chk("mid_req_ready_0", {30'd0, req_ready}, 32'd1);
        next_cycle();
        req_valid = 2'b10;
        push(1'b1, 32'd3, 1'b0);
        @(negedge clk);
        chk("mid_req_ready_1", {30'd0, req_ready}, 32'd2);
        next_cycle();
        req_valid = 2'b01;
        @(negedge clk);
        chk("mid_req_ready_2", {30'd0, req_ready}, 32'd1);
        next_cycle();
        req_valid = 2'b00;
        resp_ready = 1'b0;
        @(negedge clk);
        chk("mid_held_valid", {31'd0, resp_valid}, 32'd1);
        chk("mid_held_hart", {31'd0, resp_hart}, 32'd0);
        chk("mid_held_c", resp_c, 32'd12);
`ifdef ALU_ARB_PERF_EN
        chk("perf_grant0_pre", perf_grant0, 32'd2);
        chk("perf_grant1_pre", perf_grant1, 32'd1);
        chk("perf_conflict_pre", perf_conflict, 32'd1);
`endif
        next_cycle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_resp_valid", {31'd0, resp_valid}, 32'd0);
`ifdef ALU_ARB_PERF_EN
        chk("perf_grant0_post", perf_grant0, 32'd0);
        chk("perf_grant1_post", perf_grant1, 32'd0);
        chk("perf_conflict_post", perf_conflict, 32'd0);
`endif
        next_cycle();
        resp_ready = 1'b1;
        repeat (2) @(negedge clk);

        chk("sb_empty", sb_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
